// File: rtl/yc_pkg.sv
// Shared types for the Y/C encoder configuration scheduler: the configuration
// bundle layout, the NTSC default phase increment and the scheduler states.
package yc_pkg;

    localparam int unsigned YC_INC_W = 40;

    localparam logic [39:0] NTSC_INC = 40'd45812728235;

    // Field order matches the request/active bundle concatenation, MSB first.
    typedef struct packed {
        logic                pal;
        logic                yc_en;
        logic                mulflag;
        logic [4:0]          chroma_add;
        logic [4:0]          chroma_mul;
        logic [YC_INC_W-1:0] phase_inc;
    } yc_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT
    } yc_state_e;

endpackage

// File: rtl/yc_sync_edges.sv
// Registers hsync/vsync and produces single-cycle rising-edge strobes:
// fs marks a frame start, ls marks a line start.
module yc_sync_edges (
    input  logic clk,
    input  logic reset_n,
    input  logic hsync,
    input  logic vsync,
    output logic fs,
    output logic ls
);

    logic hsync_q;
    logic vsync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
        end
    end

    assign fs = vsync & ~vsync_q;
    assign ls = hsync & ~hsync_q;

endmodule

// File: rtl/yc_cfg_scheduler.sv
// Holds requested Y/C encoder settings until they have been stable for a number
// of frames, then applies them atomically at a frame start (or on watchdog expiry).
module yc_cfg_scheduler
    import yc_pkg::*;
#(
    parameter int unsigned      INC_W         = 40,
    parameter logic [INC_W-1:0] DEFAULT_INC   = INC_W'(NTSC_INC),
    parameter int unsigned      SETTLE_FRAMES = 2,
    parameter int unsigned      TIMEOUT_CYC   = 2000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             req_pal,
    input  logic             req_yc_en,
    input  logic             req_mulflag,
    input  logic [4:0]       req_chroma_add,
    input  logic [4:0]       req_chroma_mul,
    input  logic [INC_W-1:0] req_phase_inc,
    output logic             pal,
    output logic             yc_en,
    output logic             mulflag,
    output logic [4:0]       chroma_add,
    output logic [4:0]       chroma_mul,
    output logic [INC_W-1:0] phase_inc,
    output logic             phase_rst,
    output logic             pal_line,
    output logic             cfg_busy,
    output logic             cfg_applied,
    output logic             timeout
);

    localparam int unsigned BW     = INC_W + 13;
    localparam int unsigned FCNT_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam int unsigned WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SETTLE_FRAMES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    yc_state_e         state;
    logic [BW-1:0]     shadow;
    logic [FCNT_W-1:0] fcnt;
    logic [WDOG_W-1:0] wdog;
    logic              forced;
    logic              fs;
    logic              ls;
    logic [BW-1:0]     req_bundle;
    logic [BW-1:0]     act_bundle;

    assign req_bundle = {req_pal, req_yc_en, req_mulflag, req_chroma_add, req_chroma_mul, req_phase_inc};
    assign act_bundle = {pal, yc_en, mulflag, chroma_add, chroma_mul, phase_inc};

    yc_sync_edges u_edges (
        .clk     (clk),
        .reset_n (reset_n),
        .hsync   (hsync),
        .vsync   (vsync),
        .fs      (fs),
        .ls      (ls)
    );

    // A recapture always restarts the settle window, even on a frame start;
    // the active bundle is only ever written in COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shadow      <= '0;
            fcnt        <= '0;
            wdog        <= '0;
            forced      <= 1'b0;
            pal         <= 1'b0;
            yc_en       <= 1'b0;
            mulflag     <= 1'b0;
            chroma_add  <= '0;
            chroma_mul  <= '0;
            phase_inc   <= DEFAULT_INC;
            phase_rst   <= 1'b0;
            cfg_applied <= 1'b0;
            timeout     <= 1'b0;
            cfg_busy    <= 1'b0;
            pal_line    <= 1'b0;
        end else begin
            phase_rst   <= 1'b0;
            cfg_applied <= 1'b0;
            timeout     <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_bundle != act_bundle) begin
                        shadow   <= req_bundle;
                        fcnt     <= '0;
                        wdog     <= '0;
                        cfg_busy <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (req_bundle != shadow) begin
                        shadow <= req_bundle;
                        fcnt   <= '0;
                        wdog   <= '0;
                    end else if (fs && (fcnt == FCNT_LAST)) begin
                        state <= COMMIT;
                    end else if (fs) begin
                        if (fcnt < FCNT_LAST) begin
                            fcnt <= fcnt + 1'b1;
                        end
                        wdog <= '0;
                    end else if (wdog == WDOG_LAST) begin
                        forced <= 1'b1;
                        state  <= COMMIT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                COMMIT: begin
                    {pal, yc_en, mulflag, chroma_add, chroma_mul, phase_inc} <= shadow;
                    phase_rst   <= 1'b1;
                    cfg_applied <= 1'b1;
                    timeout     <= forced;
                    forced      <= 1'b0;
                    cfg_busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase

            // V-switch parity restarts each frame and whenever the standard flips.
            if (fs) begin
                pal_line <= 1'b0;
            end else if ((state == COMMIT) && (shadow[BW-1] != pal)) begin
                pal_line <= 1'b0;
            end else if (!pal) begin
                pal_line <= 1'b0;
            end else if (ls) begin
                pal_line <= ~pal_line;
            end
        end
    end

endmodule
